// File: rtl/cdc_tx_hold.sv
// Purpose: source-side launcher for the CDC path; registers a word onto the launch bus and toggles req_o once per word.
// Latency: 1 clk from accept to data_o/req_o; each word is held for at least HOLD_CYCLES+1 clks.
// Backpressure: ready_o is low for the whole HOLD phase, which is extended until ack_i == req_o when CDC_TX_ACK_EN is defined.
module cdc_tx_hold #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] data_o,
    output logic             req_o,
    input  logic             ack_i,
    output logic             err_o
);

    // Counter is wide enough for HOLD_CYCLES-1, and never narrower than one bit.
    localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic          accept;
    logic          release_ok;

    assign ready_o = (state_q == IDLE);
    assign accept  = valid_i && ready_o;

`ifdef CDC_TX_ACK_EN
    // Leave HOLD only once the destination has echoed the current request toggle.
    assign release_ok = (ack_i == req_o);

    // A mismatch while idle means the acknowledge toggled with nothing in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (state_q == IDLE && ack_i != req_o) begin
            err_o <= 1'b1;
        end
    end
`else
    logic unused_ack;

    // Purely time-based release; the acknowledge input is not consulted.
    assign release_ok = 1'b1;
    assign unused_ack = ack_i;
    assign err_o      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: launch on accept, return to IDLE once the hold time has expired and release is allowed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == '0 && release_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Launch bus, request toggle and hold counter; bus and toggle only move on an accept edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o <= '0;
            req_o  <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            data_o <= data_i;
            req_o  <= ~req_o;
            cnt_q  <= CNT_LOAD;
        end else if (state_q == HOLD && cnt_q != '0) begin
            cnt_q  <= cnt_q - 1'b1;
        end
    end

endmodule
